// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART packet ALU: opcodes, FSM state encodings
// and the header size.
package uart_alu_pkg;

   typedef enum logic [7:0] {
      OP_ECHO = 8'hEC,
      OP_ADD  = 8'hAD,
      OP_MUL  = 8'h88,
      OP_DIV  = 8'hD1
   } opcode_e;

   typedef enum logic [2:0] {
      S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_EXEC, S_RESULT
   } pstate_e;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

   localparam int HDR_BYTES = 4;

   function automatic logic is_alu_op(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/uart_alu_div.sv
// Iterative restoring 32/32 unsigned divider: one load cycle, then one quotient bit
// per clock for 32 clocks. A zero divisor naturally produces an all-ones quotient.
module uart_alu_div (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient
);
   logic [31:0] rem;
   logic [31:0] dvs;
   logic [4:0]  cnt;
   logic [32:0] trial;

   // bit 32 set means the shifted remainder is below the divisor (restore)
   assign trial = {rem, quotient[31]} - {1'b0, dvs};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            quotient <= dividend;
            dvs      <= divisor;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
         end else if (busy) begin
            if (!trial[32]) begin
               rem      <= trial[31:0];
               quotient <= {quotient[30:0], 1'b1};
            end else begin
               rem      <= {rem[30:0], quotient[31]};
               quotient <= {quotient[30:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_alu.sv
// UART packet processor: 8N1 receiver, header/payload parser with ECHO/ADD/MUL/DIV,
// and an 8N1 transmitter fed through a one-entry hold register.
module uart_alu
   import uart_alu_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115_200
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rx_i,
   output logic tx_o
);
   localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

   // ---------------- RX ----------------
   logic          rx_m, rx_s, rx_d;
   rx_state_e     rx_st, rx_st_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_vld, rx_vld_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) {rx_m, rx_s, rx_d} <= 3'b111;
      else         {rx_m, rx_s, rx_d} <= {rx_i, rx_m, rx_s};
   end

   always_comb begin
      rx_st_n  = rx_st;
      rx_cnt_n = rx_cnt + 1'b1;
      rx_bit_n = rx_bit;
      rx_sh_n  = rx_sh;
      rx_vld_n = 1'b0;
      case (rx_st)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (rx_d && !rx_s) rx_st_n = RX_START;
         end
         RX_START: if (rx_cnt == HALF_LAST) begin
            // a start that is high again at half-bit was a glitch
            rx_cnt_n = '0;
            rx_bit_n = '0;
            rx_st_n  = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt == BIT_LAST) begin
            rx_cnt_n = '0;
            rx_sh_n  = {rx_s, rx_sh[7:1]};
            rx_bit_n = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st_n = RX_STOP;
         end
         RX_STOP: if (rx_cnt == BIT_LAST) begin
            rx_vld_n = rx_s;
            rx_st_n  = RX_IDLE;
         end
         default: rx_st_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_st  <= RX_IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh  <= '0;
         rx_vld <= 1'b0;
      end else begin
         rx_st  <= rx_st_n;
         rx_cnt <= rx_cnt_n;
         rx_bit <= rx_bit_n;
         rx_sh  <= rx_sh_n;
         rx_vld <= rx_vld_n;
      end
   end

   // ---------------- parser / ALU ----------------
   pstate_e     p_st, p_st_n;
   logic [7:0]  opcode, opcode_n;
   logic [7:0]  len_lo, len_lo_n;
   logic [15:0] len_w;
   logic [15:0] rem, rem_n;
   logic        alu_ok, alu_ok_n;
   logic        first, first_n;
   logic [23:0] opnd, opnd_n;
   logic [1:0]  bcnt, bcnt_n;
   logic [31:0] acc, acc_n;
   logic [31:0] word;
   logic [31:0] res_buf, res_buf_n;
   logic [2:0]  res_left, res_left_n;
   logic        push;
   logic [7:0]  push_data;
   logic        hold_vld;
   logic        div_start, div_busy, div_done;
   logic [31:0] div_q;

   assign len_w = {rx_sh, len_lo};
   assign word  = {rx_sh, opnd};

   always_comb begin
      p_st_n     = p_st;
      opcode_n   = opcode;
      len_lo_n   = len_lo;
      rem_n      = rem;
      alu_ok_n   = alu_ok;
      first_n    = first;
      opnd_n     = opnd;
      bcnt_n     = bcnt;
      acc_n      = acc;
      res_buf_n  = res_buf;
      res_left_n = res_left;
      push       = 1'b0;
      push_data  = res_buf[7:0];
      div_start  = 1'b0;

      // result bytes drain independently so the parser can take the next header
      if (res_left != 3'd0 && !hold_vld) begin
         push       = 1'b1;
         res_buf_n  = res_buf >> 8;
         res_left_n = res_left - 3'd1;
      end

      case (p_st)
         S_OPCODE: if (rx_vld) begin
            opcode_n = rx_sh;
            p_st_n   = S_RSVD;
         end
         S_RSVD: if (rx_vld) p_st_n = S_LEN_LO;
         S_LEN_LO: if (rx_vld) begin
            len_lo_n = rx_sh;
            p_st_n   = S_LEN_HI;
         end
         S_LEN_HI: if (rx_vld) begin
            rem_n    = (len_w > 16'(HDR_BYTES)) ? len_w - 16'(HDR_BYTES) : 16'd0;
            alu_ok_n = is_alu_op(opcode) && (rem_n[1:0] == 2'd0) && (rem_n >= 16'd8);
            first_n  = 1'b1;
            bcnt_n   = '0;
            p_st_n   = (rem_n == 16'd0) ? S_OPCODE : S_PAYLOAD;
         end
         S_PAYLOAD: if (rx_vld) begin
            rem_n = rem - 16'd1;
            if (opcode == OP_ECHO && !hold_vld && !push) begin
               push      = 1'b1;
               push_data = rx_sh;
            end
            if (alu_ok) begin
               opnd_n = word[31:8];
               bcnt_n = bcnt + 2'd1;
               if (bcnt == 2'd3) begin
                  if (first) begin
                     acc_n   = word;
                     first_n = 1'b0;
                  end else if (opcode == OP_ADD) begin
                     acc_n = acc + word;
                  end else if (opcode == OP_MUL) begin
                     acc_n = acc * word;
                  end else begin
                     div_start = 1'b1;
                     p_st_n    = S_EXEC;
                  end
               end
            end
            if (rem_n == 16'd0 && p_st_n == S_PAYLOAD)
               p_st_n = alu_ok ? S_RESULT : S_OPCODE;
         end
         S_EXEC: if (div_done && !div_busy) begin
            acc_n  = div_q;
            p_st_n = (rem == 16'd0) ? S_RESULT : S_PAYLOAD;
         end
         S_RESULT: begin
            res_buf_n  = acc;
            res_left_n = 3'd4;
            p_st_n     = S_OPCODE;
         end
         default: p_st_n = S_OPCODE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_st     <= S_OPCODE;
         opcode   <= '0;
         len_lo   <= '0;
         rem      <= '0;
         alu_ok   <= 1'b0;
         first    <= 1'b0;
         opnd     <= '0;
         bcnt     <= '0;
         acc      <= '0;
         res_buf  <= '0;
         res_left <= '0;
      end else begin
         p_st     <= p_st_n;
         opcode   <= opcode_n;
         len_lo   <= len_lo_n;
         rem      <= rem_n;
         alu_ok   <= alu_ok_n;
         first    <= first_n;
         opnd     <= opnd_n;
         bcnt     <= bcnt_n;
         acc      <= acc_n;
         res_buf  <= res_buf_n;
         res_left <= res_left_n;
      end
   end

   uart_alu_div u_div (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start    (div_start),
      .dividend (acc),
      .divisor  (word),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   // ---------------- TX ----------------
   tx_state_e     tx_st, tx_st_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          tx_q, tx_q_n;
   logic          tx_take;
   logic          hold_vld_n;
   logic [7:0]    hold_data, hold_data_n;

   always_comb begin
      tx_st_n     = tx_st;
      tx_cnt_n    = tx_cnt + 1'b1;
      tx_bit_n    = tx_bit;
      tx_sh_n     = tx_sh;
      tx_q_n      = tx_q;
      tx_take     = 1'b0;
      hold_vld_n  = hold_vld;
      hold_data_n = hold_data;
      case (tx_st)
         TX_IDLE: begin
            tx_cnt_n = '0;
            tx_q_n   = 1'b1;
            if (hold_vld) begin
               tx_take = 1'b1;
               tx_sh_n = hold_data;
               tx_q_n  = 1'b0;
               tx_st_n = TX_START;
            end
         end
         TX_START: if (tx_cnt == BIT_LAST) begin
            tx_cnt_n = '0;
            tx_bit_n = '0;
            tx_q_n   = tx_sh[0];
            tx_st_n  = TX_DATA;
         end
         TX_DATA: if (tx_cnt == BIT_LAST) begin
            tx_cnt_n = '0;
            if (tx_bit == 3'd7) begin
               tx_q_n  = 1'b1;
               tx_st_n = TX_STOP;
            end else begin
               tx_sh_n  = tx_sh >> 1;
               tx_q_n   = tx_sh[1];
               tx_bit_n = tx_bit + 3'd1;
            end
         end
         TX_STOP: if (tx_cnt == BIT_LAST) begin
            tx_cnt_n = '0;
            // chain straight into the next start bit when a byte is waiting
            if (hold_vld) begin
               tx_take = 1'b1;
               tx_sh_n = hold_data;
               tx_q_n  = 1'b0;
               tx_st_n = TX_START;
            end else begin
               tx_q_n  = 1'b1;
               tx_st_n = TX_IDLE;
            end
         end
         default: tx_st_n = TX_IDLE;
      endcase
      if (tx_take) hold_vld_n = 1'b0;
      if (push) begin
         hold_vld_n  = 1'b1;
         hold_data_n = push_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_st     <= TX_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_sh     <= '0;
         tx_q      <= 1'b1;
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else begin
         tx_st     <= tx_st_n;
         tx_cnt    <= tx_cnt_n;
         tx_bit    <= tx_bit_n;
         tx_sh     <= tx_sh_n;
         tx_q      <= tx_q_n;
         hold_vld  <= hold_vld_n;
         hold_data <= hold_data_n;
      end
   end

   assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_alu.sv
// Directed bench for uart_alu at 16 clocks per bit: drives framed packets on rx_i,
// decodes tx_o into a byte queue and compares against hand-computed responses.
module tb_uart_alu;

   localparam int CPB = 16;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic rx_i = 1'b1;
   logic tx_o;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   stop_cyc = 0;
   int   tx_ferr = 0;
   bq_t  mon_q;
   int   mon_t[$];

   uart_alu #(.CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .rx_i   (rx_i),
      .tx_o   (tx_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // tx_o decoder: samples at mid-bit on the falling clock edge
   initial begin : tx_mon
      logic [7:0] b;
      int t0;
      forever begin
         @(negedge clk);
         if (tx_o === 1'b0) begin
            t0 = cyc;
            repeat (CPB/2 - 1) @(negedge clk);
            if (tx_o !== 1'b0) tx_ferr++;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx_o;
            end
            repeat (CPB) @(negedge clk);
            if (tx_o !== 1'b1) tx_ferr++;
            mon_q.push_back(b);
            mon_t.push_back(t0);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      @(negedge clk);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = stop;
      stop_cyc = cyc;
      repeat (CPB) @(negedge clk);
      rx_i = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_pkt(input bq_t p);
      foreach (p[i]) send_byte(p[i]);
   endtask

   task automatic clr();
      mon_q.delete();
      mon_t.delete();
   endtask

   task automatic expect_tx(input string tag, input bq_t exp);
      int waited;
      waited = 0;
      while (mon_q.size() < exp.size() && waited < 3000) begin
         @(posedge clk);
         waited++;
      end
      repeat (400) @(posedge clk);
      chk({tag, "_cnt"}, mon_q.size(), exp.size());
      foreach (exp[i])
         chk($sformatf("%s[%0d]", tag, i), (i < mon_q.size()) ? {24'h0, mon_q[i]} : 32'hxxxx_xxxx,
             {24'h0, exp[i]});
   endtask

   bq_t none;
   int  lat;

   initial begin
      // reset state
      repeat (5) @(negedge clk);
      chk("rst_tx", tx_o, 1);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_tx", tx_o, 1);

      // echo
      clr();
      send_pkt('{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69});
      expect_tx("echo", '{8'h42, 8'h69, 8'h42, 8'h69});
      lat = (mon_t.size() == 4) ? mon_t[3] - stop_cyc : 9999;
      chk("echo_lat_ok", lat <= 14, 1);

      // add, with back-to-back result bytes
      clr();
      send_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00});
      expect_tx("add", '{8'h10, 8'h00, 8'h00, 8'h00});
      chk("add_gap01", (mon_t.size() == 4) ? mon_t[1] - mon_t[0] : 0, CPB * 10);
      chk("add_gap23", (mon_t.size() == 4) ? mon_t[3] - mon_t[2] : 0, CPB * 10);

      // mul wrap, next packet's header arriving while the result is sent
      clr();
      send_pkt('{8'h88, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00});
      send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h3C});
      expect_tx("mul", '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h3C});

      // div fold 100/5/4
      clr();
      send_pkt('{8'hD1, 8'h00, 8'h10, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
                 8'h05, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00});
      expect_tx("div", '{8'h05, 8'h00, 8'h00, 8'h00});
      lat = (mon_t.size() > 0) ? mon_t[0] - stop_cyc : 9999;
      chk("div_lat_ok", lat <= 52, 1);

      // divide by zero
      clr();
      send_pkt('{8'hD1, 8'h00, 8'h0C, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      expect_tx("div0", '{8'hFF, 8'hFF, 8'hFF, 8'hFF});

      // divide by zero then fold continues: 0xFFFFFFFF / 16
      clr();
      send_pkt('{8'hD1, 8'h00, 8'h10, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00});
      expect_tx("div0_fold", '{8'hFF, 8'hFF, 8'hFF, 8'h0F});

      // 1-clock glitch produces no byte; following echo stays aligned
      clr();
      @(negedge clk);
      rx_i = 1'b0;
      @(negedge clk);
      rx_i = 1'b1;
      repeat (100) @(negedge clk);
      send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'hA5});
      expect_tx("glitch", '{8'hA5});

      // framing error byte is dropped and not counted
      clr();
      send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00});
      send_byte(8'h11, 1'b0);
      send_pkt('{8'h22, 8'h33, 8'h44});
      expect_tx("frame", '{8'h22, 8'h33, 8'h44});

      // unknown opcode consumed silently, echo afterwards
      clr();
      send_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
      send_pkt('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hC3});
      expect_tx("unknown", '{8'h5A, 8'hC3});

      // boundaries: empty echo, bad ALU lengths, short LENGTH
      clr();
      send_pkt('{8'hEC, 8'h00, 8'h04, 8'h00});
      send_pkt('{8'hAD, 8'h00, 8'h0B, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
      send_pkt('{8'hAD, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00});
      send_pkt('{8'hEC, 8'h00, 8'h02, 8'h00});
      expect_tx("bound_none", none);
      clr();
      send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77});
      expect_tx("bound_echo", '{8'h77});

      // reset mid-packet
      clr();
      send_pkt('{8'hEC, 8'h00});
      @(negedge clk);
      rst_ni = 1'b0;
      repeat (20) @(negedge clk);
      chk("rstmid_tx", tx_o, 1);
      rst_ni = 1'b1;
      repeat (20) @(negedge clk);
      send_pkt('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h12, 8'h34});
      expect_tx("rstmid", '{8'h12, 8'h34});

      chk("tx_frame_err", tx_ferr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
